m68k_bus_arbiter: RTL

//  68000-style bus arbitration controller for the Amiga-side bus. Shares the 68K bus between the
//  Pi transaction engine and external DMA masters using the BR_n/BG_n/BGACK_n protocol.

---
 rtl/m68k_bus_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_arbiter.sv
// 68000 BR/BG/BGACK bus arbiter for the Amiga-side bus, clocked by PI_CLK.
// Shares the bus between the Pi transaction engine and external DMA masters.
module m68k_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 32,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             PI_CLK,
    input  logic             RESET_n,
    input  logic             M68K_CLK,
    input  logic             M68K_BR_n,
    input  logic             M68K_BGACK_n,
    input  logic             op_req,
    input  logic             txn_active,
    output logic             op_grant,
    output logic             bus_drive_oe,
    output logic             M68K_BG_n,
    output logic             arb_released,
    output logic             grant_timeout,
    output logic [CNT_W-1:0] grant_count
);

    localparam int unsigned TMO_W =
        (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_GRANT,
        ST_RELEASED,
        ST_RECLAIM
    } state_t;

    logic             br_meta_q;
    logic             br_s_q;
    logic             bgack_meta_q;
    logic             bgack_s_q;
    logic [2:0]       c7m_q;
    logic             c7m_fall;

    state_t           state_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             br_block_q;
    logic [CNT_W-1:0] grant_count_q;
    logic             grant_timeout_q;
    logic             op_grant_q;
    logic             oe_q;
    logic             bg_n_q;
    logic             released_q;

    // op_req is informational only; it never influences arbitration
    logic             unused_op_req;
    assign unused_op_req = op_req;

    // Two-flop synchronisers for the asynchronous BR_n / BGACK_n lines
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            br_meta_q    <= 1'b1;
            br_s_q       <= 1'b1;
            bgack_meta_q <= 1'b1;
            bgack_s_q    <= 1'b1;
        end else begin
            br_meta_q    <= M68K_BR_n;
            br_s_q       <= br_meta_q;
            bgack_meta_q <= M68K_BGACK_n;
            bgack_s_q    <= bgack_meta_q;
        end
    end

    // M68K_CLK sampled as data; its falling edge is the arbitration tick
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            c7m_q <= 3'b000;
        end else begin
            c7m_q <= {c7m_q[1:0], M68K_CLK};
        end
    end

    assign c7m_fall = c7m_q[2] & ~c7m_q[1];

    // Arbitration FSM with registered outputs one PI_CLK behind the state
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q         <= ST_RELEASED;
            tmo_cnt_q       <= '0;
            br_block_q      <= 1'b0;
            grant_count_q   <= '0;
            grant_timeout_q <= 1'b0;
            op_grant_q      <= 1'b0;
            oe_q            <= 1'b0;
            bg_n_q          <= 1'b1;
            released_q      <= 1'b1;
        end else begin
            grant_timeout_q <= 1'b0;
            // A negated BR lifts the post-timeout block so a stuck
            // requester cannot lock the engine out forever
            if (br_s_q) begin
                br_block_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (txn_active) begin
                        state_q <= ST_BUSY;
                    end else if (c7m_fall && !br_s_q && !br_block_q) begin
                        state_q   <= ST_GRANT;
                        tmo_cnt_q <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!txn_active) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (c7m_fall) begin
                        if (!bgack_s_q) begin
                            state_q       <= ST_RELEASED;
                            grant_count_q <= grant_count_q + 1'b1;
                        end else if (br_s_q) begin
                            state_q <= ST_IDLE;
                        end else if (GRANT_TIMEOUT != 0 &&
                                     tmo_cnt_q == TMO_LAST) begin
                            state_q         <= ST_IDLE;
                            grant_timeout_q <= 1'b1;
                            br_block_q      <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RELEASED: begin
                    if (c7m_fall && bgack_s_q) begin
                        state_q <= ST_RECLAIM;
                    end
                end
                ST_RECLAIM: begin
                    if (c7m_fall) begin
                        if (!br_s_q && !br_block_q) begin
                            state_q   <= ST_GRANT;
                            tmo_cnt_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RELEASED;
                end
            endcase

            op_grant_q <= (state_q == ST_IDLE) && (br_s_q || br_block_q);
            oe_q       <= (state_q != ST_RELEASED);
            released_q <= (state_q == ST_RELEASED);
            if (state_q == ST_GRANT) begin
                bg_n_q <= 1'b0;
            end else if (state_q == ST_RELEASED) begin
                bg_n_q <= br_s_q;
            end else begin
                bg_n_q <= 1'b1;
            end
        end
    end

    assign op_grant      = op_grant_q;
    assign bus_drive_oe  = oe_q;
    assign M68K_BG_n     = bg_n_q;
    assign arb_released  = released_q;
    assign grant_timeout = grant_timeout_q;
    assign grant_count   = grant_count_q;

endmodule
